adder_accumulator: RTL and testbench

Streaming accumulator placed directly downstream of the ripple-carry `Multibit_Adder`. It consumes that adder's N+1-bit sums one beat per cycle under a valid/ready handshake and accumulates a burst into a wider saturating register. It presents the burst total, the term count and an overflow flag to the next stage under a second valid/ready handshake.

---
 rtl/adder_acc_pkg.sv | 22 ++
 rtl/Multibit_Adder.sv | 24 ++
 rtl/acc_sat_add.sv | 28 ++
 rtl/adder_accumulator.sv | 109 ++++++++++
 tb/tb_adder_accumulator.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_acc_pkg.sv
// Shared types and defaults for the saturating burst accumulator.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package adder_acc_pkg;

    // Default geometry: 8-bit adder operands give 9-bit sums into a 16-bit accumulator.
    localparam int DEF_N         = 8;
    localparam int DEF_ACC_W     = 16;
    localparam int DEF_MAX_TERMS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    // The term counter has to be able to hold MAX_TERMS itself, not just MAX_TERMS-1.
    function automatic int calc_cw(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/Multibit_Adder.sv
// Ripple-carry adder: two N-bit unsigned operands, N+1-bit sum.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a, i_b (N-bit operands); o_sum (N+1 bits, MSB is carry-out).
module Multibit_Adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N:0]   o_sum
);

    logic [N:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_sum[N] = w_carry[N];

endmodule

// File: rtl/acc_sat_add.sv
// Unsigned W-bit add that clamps to all-ones on carry-out and flags it.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a, i_b (W-bit operands); o_sum (W-bit saturated result); o_ovf (carry-out seen).
module acc_sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);

    logic [W:0] w_raw;

    Multibit_Adder #(
        .N (W)
    ) u_add (
        .i_a   (i_a),
        .i_b   (i_b),
        .o_sum (w_raw)
    );

    // Bit W is the adder's carry-out; once it fires the true total no longer fits.
    assign o_ovf = w_raw[W];
    assign o_sum = w_raw[W] ? {W{1'b1}} : w_raw[W-1:0];

endmodule

// File: rtl/adder_accumulator.sv
// Accumulates a burst of unsigned N+1-bit sums into a saturating ACC_W-bit total.
// Latency: out_valid rises the cycle after the closing beat; one beat per cycle in a burst.
// Backpressure: in_ready drops while a result is held; result stays stable until out_ready.
// Ports: clk, rst_n (async active-low), clear (sync abort);
//        in_valid/in_ready/in_sum/in_last (beat stream);
//        out_valid/out_ready/out_acc/out_count/out_ovf (burst result).
module adder_accumulator
    import adder_acc_pkg::*;
#(
    parameter  int N         = DEF_N,
    parameter  int ACC_W     = DEF_ACC_W,
    parameter  int MAX_TERMS = DEF_MAX_TERMS,
    localparam int CW        = calc_cw(MAX_TERMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       in_sum,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CW-1:0]    out_count,
    output logic             out_ovf
);

    acc_state_t       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic [ACC_W-1:0] w_in_ext;
    logic [ACC_W-1:0] w_sat_sum;
    logic             w_sat_ovf;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [CW-1:0]    w_count_inc;
    logic             w_cap;

    assign w_in_ext    = ACC_W'(in_sum);
    assign in_ready    = (r_state != HOLD) && !clear;
    assign out_valid   = (r_state == HOLD);
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_count_inc = r_count + CW'(1);
    // Burst closes at the cap even if the producer never marks a last beat.
    assign w_cap       = (w_count_inc == CW'(MAX_TERMS));

    assign out_acc   = r_acc;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;

    acc_sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_in_ext),
        .o_sum (w_sat_sum),
        .o_ovf (w_sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            // Abort wins over any beat or result handshake in the same cycle.
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        r_acc   <= w_in_ext;
                        r_count <= CW'(1);
                        r_ovf   <= 1'b0;
                        r_state <= (in_last || MAX_TERMS == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_in_fire) begin
                        r_acc   <= w_sat_sum;
                        r_count <= w_count_inc;
                        r_ovf   <= r_ovf | w_sat_ovf;
                        r_state <= (in_last || w_cap) ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (w_out_fire) begin
                        r_state <= IDLE;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_accumulator.sv
module tb_adder_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [8:0]  in_sum;
    logic        in_last;
    logic        out_ready;

    // Default instance: N=8, ACC_W=16, MAX_TERMS=16
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_acc;
    logic [4:0]  out_count;
    logic        out_ovf;

    // Narrow instance for saturation: ACC_W=12
    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [11:0] s_out_acc;
    logic [4:0]  s_out_count;
    logic        s_out_ovf;

    int n_tests;
    int n_fail;

    adder_accumulator #(
        .N         (8),
        .ACC_W     (16),
        .MAX_TERMS (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    adder_accumulator #(
        .N         (8),
        .ACC_W     (12),
        .MAX_TERMS (16)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_sum    (in_sum),
        .in_last   (in_last),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_acc   (s_out_acc),
        .out_count (s_out_count),
        .out_ovf   (s_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input bit sel, input logic [8:0] s, input logic l);
        bit accepted;
        accepted = 1'b0;
        in_sum   = s;
        in_last  = l;
        if (sel) s_in_valid = 1'b1;
        else     in_valid   = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = sel ? s_in_ready : in_ready;
            @(posedge clk);
            #1;
        end
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        in_last    = 1'b0;
        if (!accepted) check("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    // Pops a held result; leaves the bench just after the handshake edge.
    task automatic take_result();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        in_sum     = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_acc",   32'(out_acc),   32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst 100+200+300
        send_beat(1'b0, 9'd100, 1'b0);
        send_beat(1'b0, 9'd200, 1'b0);
        @(negedge clk);
        check("basic_mid_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send_beat(1'b0, 9'd300, 1'b1);
        @(negedge clk);
        check("basic_valid",    32'(out_valid), 32'd1);
        check("basic_acc",      32'(out_acc),   32'd600);
        check("basic_count",    32'(out_count), 32'd3);
        check("basic_ovf",      32'(out_ovf),   32'd0);
        check("basic_in_ready", 32'(in_ready),  32'd0);
        take_result();
        @(negedge clk);
        check("basic_pop_ready", 32'(in_ready),  32'd1);
        check("basic_pop_valid", 32'(out_valid), 32'd0);
        check("basic_pop_acc",   32'(out_acc),   32'd0);
        @(posedge clk);
        #1;

        // Cap at 16 beats of 510, then backpressure with a 17th beat offered
        for (int i = 0; i < 16; i++) send_beat(1'b0, 9'd510, 1'b0);
        in_sum   = 9'd5;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("cap_valid",    32'(out_valid), 32'd1);
            check("cap_acc",      32'(out_acc),   32'd8160);
            check("cap_count",    32'(out_count), 32'd16);
            check("cap_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("cap_pop_ready", 32'(in_ready),  32'd1);
        check("cap_pop_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("cap_next_valid", 32'(out_valid), 32'd1);
        check("cap_next_acc",   32'(out_acc),   32'd5);
        check("cap_next_count", 32'(out_count), 32'd1);
        take_result();

        // Saturation on the 12-bit instance: 9 x 510 = 4590 > 4095
        for (int i = 0; i < 8; i++) send_beat(1'b1, 9'd510, 1'b0);
        send_beat(1'b1, 9'd510, 1'b1);
        @(negedge clk);
        check("sat_valid", 32'(s_out_valid), 32'd1);
        check("sat_acc",   32'(s_out_acc),   32'd4095);
        check("sat_ovf",   32'(s_out_ovf),   32'd1);
        check("sat_count", 32'(s_out_count), 32'd9);
        // Clear while a result is held discards it
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("sat_clr_valid", 32'(s_out_valid), 32'd0);
        check("sat_clr_ovf",   32'(s_out_ovf),   32'd0);
        check("sat_clr_acc",   32'(s_out_acc),   32'd0);
        @(posedge clk);
        #1;

        // Clear mid-burst, beat offered alongside clear is dropped
        send_beat(1'b0, 9'd50, 1'b0);
        send_beat(1'b0, 9'd50, 1'b0);
        clear    = 1'b1;
        in_sum   = 9'd99;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("clr_in_ready", 32'(in_ready),  32'd0);
        check("clr_pre_count", 32'(out_count), 32'd2);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("clr_count", 32'(out_count), 32'd0);
        check("clr_acc",   32'(out_acc),   32'd0);
        check("clr_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send_beat(1'b0, 9'd7, 1'b1);
        @(negedge clk);
        check("clr_new_valid", 32'(out_valid), 32'd1);
        check("clr_new_acc",   32'(out_acc),   32'd7);
        check("clr_new_count", 32'(out_count), 32'd1);
        take_result();

        // Asynchronous reset mid-burst, away from any clock edge
        send_beat(1'b0, 9'd3, 1'b0);
        send_beat(1'b0, 9'd4, 1'b0);
        @(negedge clk);
        check("arst_pre_count", 32'(out_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_acc",   32'(out_acc),   32'd0);
        check("arst_out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(1'b0, 9'd1, 1'b1);
        @(negedge clk);
        check("arst_new_acc",   32'(out_acc),   32'd1);
        check("arst_new_count", 32'(out_count), 32'd1);
        take_result();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
